screen_ctrl: RTL and testbench

SCREEN_CTRL -- requirements
Module: screen_ctrl

---
 rtl/screen_ctrl_pkg.sv | 51 +++++
 rtl/screen_init_rom.sv | 23 ++
 rtl/screen_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_screen_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/screen_ctrl_pkg.sv
// Shared definitions for the screen controller: init-ROM entry types,
// panel opcodes, FSM state encodings and the fixed window-setup byte stream.
package screen_ctrl_pkg;

    typedef enum logic [1:0] {
        ENT_CMD = 2'd0,
        ENT_DAT = 2'd1,
        ENT_DLY = 2'd2,
        ENT_END = 2'd3
    } entry_t;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_RASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] COLMOD_16B = 8'h55;

    typedef enum logic [2:0] {
        ST_HWRST = 3'd0,
        ST_WAKE  = 3'd1,
        ST_INIT  = 3'd2,
        ST_WIN   = 3'd3,
        ST_FETCH = 3'd4,
        ST_PIXEL = 3'd5
    } state_t;

    localparam logic [3:0] WIN_LAST = 4'd10;

    // Window setup: CASET 0..511, RASET 0..255, then RAMWR.
    function automatic logic [7:0] win_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = OP_CASET;
            4'd3:    b = 8'h01;
            4'd4:    b = 8'hFF;
            4'd5:    b = OP_RASET;
            4'd9:    b = 8'hFF;
            4'd10:   b = OP_RAMWR;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic win_is_cmd(input logic [3:0] i);
        return (i == 4'd0) || (i == 4'd5) || (i == WIN_LAST);
    endfunction

endpackage

// File: rtl/screen_init_rom.sv
// Panel power-up script: combinational table of {type, value} entries.
module screen_init_rom
    import screen_ctrl_pkg::*;
(
    input  logic [5:0] i_idx,
    output logic [9:0] o_entry
);

    always_comb begin
        o_entry = {ENT_END, 8'h00};
        case (i_idx)
            6'd0:    o_entry = {ENT_CMD, OP_SWRESET};
            6'd1:    o_entry = {ENT_DLY, 8'd150};
            6'd2:    o_entry = {ENT_CMD, OP_SLPOUT};
            6'd3:    o_entry = {ENT_DLY, 8'd255};
            6'd4:    o_entry = {ENT_CMD, OP_COLMOD};
            6'd5:    o_entry = {ENT_DAT, COLMOD_16B};
            6'd6:    o_entry = {ENT_CMD, OP_DISPON};
            default: ;
        endcase
    end

endmodule

// File: rtl/screen_ctrl.sv
// Streams the 512x256 1-bpp Hack screen RAM to an SPI LCD panel as
// 16-bit pixels, after a hardware reset, wake delay and init script.
//
//   state | meaning
//   HWRST | lcd_resn low for RST_CYCLES
//   WAKE  | lcd_resn high, wait WAKE_CYCLES
//   INIT  | run init ROM script (cmd / data / delay / end)
//   WIN   | send column/row window and RAMWR
//   FETCH | present scr_addr, latch screen word
//   PIXEL | send 16 D16 words, LSB first
module screen_ctrl
    import screen_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 1000,
    parameter int WAKE_CYCLES = 150000,
    parameter int DLY_SHIFT   = 10,
    parameter int FRAME_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ready,
    output logic        spi_startC,
    output logic        spi_startD8,
    output logic        spi_startD16,
    output logic [15:0] spi_data,
    output logic [12:0] scr_addr,
    input  logic [15:0] scr_rdata,
    output logic        lcd_resn,
    output logic        frame_done
);

    localparam logic [17:0] RST_LAST  = 18'(RST_CYCLES - 1);
    localparam logic [17:0] WAKE_LAST = 18'(WAKE_CYCLES - 1);
    localparam logic [12:0] LAST_ADDR = 13'(FRAME_WORDS - 1);

    state_t      r_state;
    logic [17:0] r_tmr;
    logic [5:0]  r_idx;
    logic [3:0]  r_win_idx;
    logic [1:0]  r_fph;
    logic [12:0] r_addr;
    logic [12:0] r_scr_addr;
    logic [15:0] r_pix;
    logic [3:0]  r_bit;
    logic        r_hold;
    logic        r_lcd_resn;
    logic        r_frame_done;

    logic [9:0]  w_entry;
    entry_t      w_etype;
    logic [7:0]  w_evalue;
    logic [17:0] w_dly_target;
    logic        w_dly_done;
    logic        w_send;
    logic        w_fire;
    logic        w_kind_c;
    logic        w_kind_d8;
    logic        w_kind_d16;
    logic [15:0] w_data;

    screen_init_rom u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_etype      = entry_t'(w_entry[9:8]);
    assign w_evalue     = w_entry[7:0];
    assign w_dly_target = 18'(w_evalue) << DLY_SHIFT;
    assign w_dly_done   = (r_tmr + 18'd1) >= w_dly_target;

    // Payload and pulse type are decoded from registered state only, so
    // spi_data cannot move within the cycle a start pulse is high.
    always_comb begin
        w_send     = 1'b0;
        w_kind_c   = 1'b0;
        w_kind_d8  = 1'b0;
        w_kind_d16 = 1'b0;
        w_data     = 16'h0000;
        case (r_state)
            ST_INIT: begin
                if (w_etype == ENT_CMD || w_etype == ENT_DAT) begin
                    w_send    = 1'b1;
                    w_kind_c  = (w_etype == ENT_CMD);
                    w_kind_d8 = (w_etype == ENT_DAT);
                    w_data    = {8'h00, w_evalue};
                end
            end
            ST_WIN: begin
                w_send    = 1'b1;
                w_kind_c  = win_is_cmd(r_win_idx);
                w_kind_d8 = !win_is_cmd(r_win_idx);
                w_data    = {8'h00, win_byte(r_win_idx)};
            end
            ST_PIXEL: begin
                w_send     = 1'b1;
                w_kind_d16 = 1'b1;
                w_data     = r_pix[r_bit] ? 16'h0000 : 16'hFFFF;
            end
            default: ;
        endcase
    end

    // r_hold masks spi_ready for the one cycle the serializer needs to drop it.
    assign w_fire       = w_send && spi_ready && !r_hold;
    assign spi_startC   = w_fire && w_kind_c;
    assign spi_startD8  = w_fire && w_kind_d8;
    assign spi_startD16 = w_fire && w_kind_d16;
    assign spi_data     = w_data;
    assign scr_addr     = r_scr_addr;
    assign lcd_resn     = r_lcd_resn;
    assign frame_done   = r_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_HWRST;
            r_tmr        <= 18'd0;
            r_idx        <= 6'd0;
            r_win_idx    <= 4'd0;
            r_fph        <= 2'd0;
            r_addr       <= 13'd0;
            r_scr_addr   <= 13'd0;
            r_pix        <= 16'h0000;
            r_bit        <= 4'd0;
            r_hold       <= 1'b0;
            r_lcd_resn   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_hold       <= w_fire;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_HWRST: begin
                    if (r_tmr == RST_LAST) begin
                        r_tmr      <= 18'd0;
                        r_lcd_resn <= 1'b1;
                        r_state    <= ST_WAKE;
                    end else begin
                        r_tmr <= r_tmr + 18'd1;
                    end
                end
                ST_WAKE: begin
                    if (r_tmr == WAKE_LAST) begin
                        r_tmr   <= 18'd0;
                        r_idx   <= 6'd0;
                        r_state <= ST_INIT;
                    end else begin
                        r_tmr <= r_tmr + 18'd1;
                    end
                end
                ST_INIT: begin
                    case (w_etype)
                        ENT_CMD, ENT_DAT: begin
                            if (w_fire) r_idx <= r_idx + 6'd1;
                        end
                        ENT_DLY: begin
                            if (w_dly_done) begin
                                r_tmr <= 18'd0;
                                r_idx <= r_idx + 6'd1;
                            end else begin
                                r_tmr <= r_tmr + 18'd1;
                            end
                        end
                        default: begin
                            r_win_idx <= 4'd0;
                            r_state   <= ST_WIN;
                        end
                    endcase
                end
                ST_WIN: begin
                    if (w_fire) begin
                        if (r_win_idx == WIN_LAST) begin
                            r_addr  <= 13'd0;
                            r_fph   <= 2'd0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_win_idx <= r_win_idx + 4'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    // ph0 presents the address, ph1 covers RAM latency, ph2 latches.
                    case (r_fph)
                        2'd0: begin
                            r_scr_addr <= r_addr;
                            r_fph      <= 2'd1;
                        end
                        2'd1: r_fph <= 2'd2;
                        default: begin
                            r_pix   <= scr_rdata;
                            r_bit   <= 4'd0;
                            r_fph   <= 2'd0;
                            r_state <= ST_PIXEL;
                        end
                    endcase
                end
                ST_PIXEL: begin
                    if (w_fire) begin
                        if (r_bit == 4'd15) begin
                            r_fph <= 2'd0;
                            if (r_addr == LAST_ADDR) begin
                                r_frame_done <= 1'b1;
                                r_addr       <= 13'd0;
                                r_win_idx    <= 4'd0;
                                r_state      <= ST_WIN;
                            end else begin
                                r_addr  <= r_addr + 13'd1;
                                r_state <= ST_FETCH;
                            end
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_HWRST;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl with an SPI busy model, a screen RAM model
// and a scoreboard of expected command/data/pixel transfers.
module tb_screen_ctrl;

    localparam int RST_C  = 8;
    localparam int WAKE_C = 20;
    localparam int FW     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_ready = 1'b1;
    logic        spi_startC, spi_startD8, spi_startD16;
    logic [15:0] spi_data;
    logic [12:0] scr_addr;
    logic [15:0] scr_rdata = 16'h0000;
    logic        lcd_resn;
    logic        frame_done;

    always #5 clk = ~clk;

    screen_ctrl #(
        .RST_CYCLES  (RST_C),
        .WAKE_CYCLES (WAKE_C),
        .DLY_SHIFT   (0),
        .FRAME_WORDS (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_ready    (spi_ready),
        .spi_startC   (spi_startC),
        .spi_startD8  (spi_startD8),
        .spi_startD16 (spi_startD16),
        .spi_data     (spi_data),
        .scr_addr     (scr_addr),
        .scr_rdata    (scr_rdata),
        .lcd_resn     (lcd_resn),
        .frame_done   (frame_done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [17:0] q[$];
    logic [15:0] mem [0:FW-1];
    logic [12:0] prev_addr = 13'd0;
    int          busy = 0;
    bit          hold_low = 1'b0;
    int          cyc = 0;
    int          last_pulse = -100;
    int          pulse_total = 0;
    int          d16_total = 0;
    int          fd_count = 0;
    int          fd_at = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] d);
        q.push_back({k, d});
    endtask

    task automatic push_rom();
        push(2'd0, 16'h0001);
        push(2'd0, 16'h0011);
        push(2'd0, 16'h003A);
        push(2'd1, 16'h0055);
        push(2'd0, 16'h0029);
    endtask

    task automatic push_win();
        push(2'd0, 16'h002A);
        push(2'd1, 16'h0000); push(2'd1, 16'h0000);
        push(2'd1, 16'h0001); push(2'd1, 16'h00FF);
        push(2'd0, 16'h002B);
        push(2'd1, 16'h0000); push(2'd1, 16'h0000);
        push(2'd1, 16'h0000); push(2'd1, 16'h00FF);
        push(2'd0, 16'h002C);
    endtask

    task automatic push_word(input int w);
        logic [15:0] v;
        v = mem[w];
        for (int b = 0; b < 16; b++) push(2'd2, v[b] ? 16'h0000 : 16'hFFFF);
    endtask

    // One clock: sample at the falling edge, then update the SPI/RAM models.
    task automatic step();
        int          np;
        logic [17:0] got_item;
        logic [17:0] exp_item;
        @(negedge clk);
        cyc++;
        np = int'(spi_startC) + int'(spi_startD8) + int'(spi_startD16);
        if (np != 0) begin
            pulse_total++;
            chk("one_start_only", 32'(np), 32'd1);
            chk("ready_at_start", 32'(spi_ready), 32'd1);
            chk("no_start_in_rst", 32'(rst), 32'd0);
            chk("start_gap_ge2", 32'(cyc - last_pulse >= 2), 32'd1);
            last_pulse = cyc;
            got_item = {(spi_startD16 ? 2'd2 : (spi_startD8 ? 2'd1 : 2'd0)), spi_data};
            if (q.size() == 0) begin
                chk("sb_unexpected", 32'(got_item), 32'h3FFFF);
            end else begin
                exp_item = q.pop_front();
                chk("sb_item", 32'(got_item), 32'(exp_item));
            end
            if (spi_startD16) d16_total++;
        end
        if (frame_done) begin
            fd_count++;
            if (fd_count == 1) fd_at = d16_total;
        end
        scr_rdata = mem[prev_addr[2:0]];
        prev_addr = scr_addr;
        if (np != 0) busy = int'($urandom_range(20, 5));
        else if (busy > 0) busy--;
        spi_ready = (busy == 0) && !hold_low;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({spi_startC, spi_startD8, spi_startD16, lcd_resn, frame_done}), 32'd0);
        chk({tag, "_bus"}, 32'({scr_addr, spi_data}), 32'd0);
    endtask

    task automatic count_resn(input string tag);
        int n = 0;
        while (!lcd_resn && n < 1000) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'(RST_C));
    endtask

    task automatic run_until_d16(input int target, input int budget, input string tag);
        int n = 0;
        while (d16_total < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(d16_total), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < FW; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0001;
        push_rom();
        push_win();
        for (int w = 0; w < FW; w++) push_word(w);
        push_win();
        push_word(0);

        repeat (3) begin
            step();
            chk_reset_outputs("por_reset");
        end
        rst = 1'b0;
        count_resn("hwrst_len_por");

        run_until_d16(1, 5000, "first_d16");
        run_until_d16(20, 3000, "reach_hold_point");

        hold_low = 1'b1;
        begin
            int p0;
            p0 = pulse_total;
            repeat (10000) step();
            chk("hold_no_start", 32'(pulse_total), 32'(p0));
            chk("hold_addr", 32'(scr_addr), 32'd1);
        end
        hold_low = 1'b0;

        run_until_d16(FW * 16, 20000, "frame1_transfers");
        run_until_d16(FW * 16 + 1, 2000, "frame2_first_d16");
        chk("frame_done_count", 32'(fd_count), 32'd1);
        chk("frame_done_after", 32'(fd_at), 32'(FW * 16));
        chk("addr_wrapped", 32'(scr_addr), 32'd0);
        chk("resn_kept_high", 32'(lcd_resn), 32'd1);

        run_until_d16(FW * 16 + 5, 2000, "frame2_mid_pixel");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_immediate");
        q.delete();
        push_rom();
        push_win();
        push_word(0);
        repeat (4) begin
            step();
            chk_reset_outputs("rst_held");
        end
        rst = 1'b0;
        count_resn("hwrst_len_mid");
        run_until_d16(FW * 16 + 5 + 16, 8000, "replay_word0");
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("frame_done_once", 32'(fd_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
